// File: rtl/vesa_timing_pkg.sv
// vesa_timing_pkg: shared timing constants and helpers for the VESA raster generator.
//   - Default 640x480@60 horizontal/vertical timing (active, porches, sync width)
//   - Sync polarity constants
//   - axis_total(): the full period of one axis, active + porches + sync
package vesa_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned CNT_BITS_DEF = 11;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vesa_timing_gen_if.sv
// vesa_timing_gen_if: raster timing bundle between the generator and the pixel stage.
//   ce                 pixel advance enable (driven by the consumer/clock side)
//   hsync, vsync, de   sync and display-enable
//   x, y               current pixel coordinates
//   frame_start        high while position is (0,0)
//   line_end           high while x is the last count of the line
// Modports: master = timing generator, slave = downstream consumer.
interface vesa_timing_gen_if #(
  parameter int unsigned CNT_BITS = 11
);
  logic                ce;
  logic                hsync;
  logic                vsync;
  logic                de;
  logic [CNT_BITS-1:0] x;
  logic [CNT_BITS-1:0] y;
  logic                frame_start;
  logic                line_end;

  modport master (
    input  ce,
    output hsync, vsync, de, x, y, frame_start, line_end
  );

  modport slave (
    output ce,
    input  hsync, vsync, de, x, y, frame_start, line_end
  );
endinterface

// File: rtl/vesa_axis_counter.sv
// vesa_axis_counter: one raster axis (horizontal or vertical).
//   clk_in, rst_n  clock, asynchronous active-low reset
//   inc            advance one count this edge
//   count          current position 0..TOTAL-1 (reset: TOTAL-1)
//   wrap           high while count == TOTAL-1
//   active         high while count < ACTIVE
//   sync           POL while ACTIVE+FP <= count < ACTIVE+FP+SYNC, else !POL
// All outputs are registered and decoded from the next count, so they line up with count.
module vesa_axis_counter
  import vesa_timing_pkg::*;
#(
  parameter int unsigned ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned FP       = H_FP_DEF,
  parameter int unsigned SYNC     = H_SYNC_DEF,
  parameter int unsigned BP       = H_BP_DEF,
  parameter bit          POL      = SYNC_ACTIVE_LOW,
  parameter int unsigned CNT_BITS = CNT_BITS_DEF
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count,
  output logic                wrap,
  output logic                active,
  output logic                sync
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  // One spare bit so a sync window ending exactly at 2^CNT_BITS still compares correctly.
  localparam int unsigned CW    = CNT_BITS + 1;

  localparam logic [CNT_BITS-1:0] LAST      = CNT_BITS'(TOTAL - 1);
  localparam logic [CW-1:0]       ACT_END   = CW'(ACTIVE);
  localparam logic [CW-1:0]       SYNC_BEG  = CW'(ACTIVE + FP);
  localparam logic [CW-1:0]       SYNC_END  = CW'(ACTIVE + FP + SYNC);

  if (64'(TOTAL) > (64'(1) << CNT_BITS)) begin : g_total_too_big
    $error("vesa_axis_counter: axis total does not fit in CNT_BITS");
  end

  logic [CNT_BITS-1:0] count_q, count_d;
  logic [CW-1:0]       count_ext;
  logic                wrap_q, active_q, sync_q;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_BITS'(1);
    end
  end

  assign count_ext = {1'b0, count_d};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= LAST;
      wrap_q   <= 1'b1;
      active_q <= 1'b0;
      sync_q   <= ~POL;
    end else begin
      count_q  <= count_d;
      wrap_q   <= (count_d == LAST);
      active_q <= (count_ext < ACT_END);
      sync_q   <= ((count_ext >= SYNC_BEG) && (count_ext < SYNC_END)) ? POL : ~POL;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign active = active_q;
  assign sync   = sync_q;

endmodule

// File: rtl/vesa_timing_gen.sv
// vesa_timing_gen: VESA/VGA raster timing for the cellular-automaton display.
//   clk_in  pixel clock (divider output) or an undivided clock with ce strobes
//   rst_n   asynchronous active-low reset; parks the raster at (H_TOTAL-1, V_TOTAL-1)
//   tif     vesa_timing_gen_if.master: ce in; hsync, vsync, de, x, y, frame_start,
//           line_end out, all registered and held while ce is low
// Build option VESA_TIMING_PIPE_EN: hsync/vsync/de get one extra ce-qualified stage so
// they lag x/y by one pixel, matching a one-cycle pixel-memory read downstream.
module vesa_timing_gen
  import vesa_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter bit          HSYNC_POL = SYNC_ACTIVE_LOW,
  parameter bit          VSYNC_POL = SYNC_ACTIVE_LOW,
  parameter int unsigned CNT_BITS  = CNT_BITS_DEF
) (
  input logic              clk_in,
  input logic              rst_n,
  vesa_timing_gen_if.master tif
);

  logic [CNT_BITS-1:0] h_count, v_count;
  logic                h_wrap, h_active, h_sync;
  logic                v_wrap, v_active, v_sync;
  logic                v_inc;
  logic                frame_start_q;

  // The vertical axis steps on the same edge the horizontal axis wraps.
  assign v_inc = tif.ce & h_wrap;

  vesa_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .POL      (HSYNC_POL),
    .CNT_BITS (CNT_BITS)
  ) u_h_axis (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    (tif.ce),
    .count  (h_count),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  vesa_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .POL      (VSYNC_POL),
    .CNT_BITS (CNT_BITS)
  ) u_v_axis (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    (v_inc),
    .count  (v_count),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (v_sync)
  );

  // Next position is (0,0) exactly when both axes sit on their last count and we advance.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q <= 1'b0;
    end else if (tif.ce) begin
      frame_start_q <= h_wrap & v_wrap;
    end
  end

  assign tif.x           = h_count;
  assign tif.y           = v_count;
  assign tif.frame_start = frame_start_q;
  assign tif.line_end    = h_wrap;

`ifdef VESA_TIMING_PIPE_EN
  logic hsync_q, vsync_q, de_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
    end else if (tif.ce) begin
      hsync_q <= h_sync;
      vsync_q <= v_sync;
      de_q    <= h_active & v_active;
    end
  end

  assign tif.hsync = hsync_q;
  assign tif.vsync = vsync_q;
  assign tif.de    = de_q;
`else
  assign tif.hsync = h_sync;
  assign tif.vsync = v_sync;
  // Both terms are flops updated on the same edge.
  assign tif.de    = h_active & v_active;
`endif

endmodule

// File: tb/tb_vesa_timing_gen.sv
// tb_vesa_timing_gen: drives a default 640x480 instance and a tiny-timing instance
// (19x12 raster, active-high hsync) from one clock, compares both against a position
// model every cycle, and pins the model with hand-computed literal expectations.
module tb_vesa_timing_gen;

`ifdef VESA_TIMING_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } tim_t;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic ce     = 1'b1;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_in = ~clk_in;

  vesa_timing_gen_if #(.CNT_BITS(11)) if0 ();
  vesa_timing_gen_if #(.CNT_BITS(5))  if1 ();
  assign if0.ce = ce;
  assign if1.ce = ce;

  vesa_timing_gen u_dut0 (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .tif    (if0)
  );

  vesa_timing_gen #(
    .H_ACTIVE (10), .H_FP (2), .H_SYNC (3), .H_BP (4),
    .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (3),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b0), .CNT_BITS (5)
  ) u_dut1 (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .tif    (if1)
  );

  function automatic tim_t tim_of(input int i);
    tim_t t;
    if (i == 0) begin
      t.ha = 640; t.hf = 16; t.hs = 96; t.hb = 48;
      t.va = 480; t.vf = 10; t.vs = 2;  t.vb = 33;
      t.hp = 1'b0; t.vp = 1'b0;
    end else begin
      t.ha = 10; t.hf = 2; t.hs = 3; t.hb = 4;
      t.va = 6;  t.vf = 1; t.vs = 2; t.vb = 3;
      t.hp = 1'b1; t.vp = 1'b0;
    end
    return t;
  endfunction

  // {hsync, vsync, de} for a raster position, straight from the timing rules.
  function automatic logic [2:0] dec(input tim_t t, input int px, input int py);
    logic hon, von, de;
    hon = (px >= t.ha + t.hf) && (px < t.ha + t.hf + t.hs);
    von = (py >= t.va + t.vf) && (py < t.va + t.vf + t.vs);
    de  = (px < t.ha) && (py < t.va);
    return {hon ? t.hp : !t.hp, von ? t.vp : !t.vp, de};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Position model: current and previous (for the delayed sync stage) per instance.
  int px[2], py[2], ppx[2], ppy[2];

  always @(posedge clk_in or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      tim_t t;
      int   ht, vt;
      t  = tim_of(i);
      ht = t.ha + t.hf + t.hs + t.hb;
      vt = t.va + t.vf + t.vs + t.vb;
      if (!rst_n) begin
        px[i]  <= ht - 1; py[i]  <= vt - 1;
        ppx[i] <= ht - 1; ppy[i] <= vt - 1;
      end else if (ce) begin
        ppx[i] <= px[i];
        ppy[i] <= py[i];
        if (px[i] == ht - 1) begin
          px[i] <= 0;
          py[i] <= (py[i] == vt - 1) ? 0 : py[i] + 1;
        end else begin
          px[i] <= px[i] + 1;
        end
      end
    end
  end

  task automatic cmp(input int i, input logic hs, input logic vs, input logic de,
                     input logic fs, input logic le, input int x, input int y);
    tim_t       t;
    int         ht;
    logic [2:0] e;
    t  = tim_of(i);
    ht = t.ha + t.hf + t.hs + t.hb;
    e  = PIPE ? dec(t, ppx[i], ppy[i]) : dec(t, px[i], py[i]);
    chk($sformatf("dut%0d_x", i), x, px[i]);
    chk($sformatf("dut%0d_y", i), y, py[i]);
    chk($sformatf("dut%0d_hsync", i), int'(hs), int'(e[2]));
    chk($sformatf("dut%0d_vsync", i), int'(vs), int'(e[1]));
    chk($sformatf("dut%0d_de", i), int'(de), int'(e[0]));
    chk($sformatf("dut%0d_frame_start", i), int'(fs), int'(px[i] == 0 && py[i] == 0));
    chk($sformatf("dut%0d_line_end", i), int'(le), int'(px[i] == ht - 1));
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      cmp(0, if0.hsync, if0.vsync, if0.de, if0.frame_start, if0.line_end,
          int'(if0.x), int'(if0.y));
      cmp(1, if1.hsync, if1.vsync, if1.de, if1.frame_start, if1.line_end,
          int'(if1.x), int'(if1.y));
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"}, int'(if0.x), 799);
    chk({tag, "_y"}, int'(if0.y), 524);
    chk({tag, "_de"}, int'(if0.de), 0);
    chk({tag, "_hsync"}, int'(if0.hsync), 1);
    chk({tag, "_vsync"}, int'(if0.vsync), 1);
    chk({tag, "_fs"}, int'(if0.frame_start), 0);
    chk({tag, "_le"}, int'(if0.line_end), 1);
    chk({tag, "_small_x"}, int'(if1.x), 18);
    chk({tag, "_small_y"}, int'(if1.y), 11);
    chk({tag, "_small_hsync"}, int'(if1.hsync), 0);
  endtask

  task automatic chk_first_edge(input string tag);
    chk({tag, "_x"}, int'(if0.x), 0);
    chk({tag, "_y"}, int'(if0.y), 0);
    chk({tag, "_fs"}, int'(if0.frame_start), 1);
    chk({tag, "_de"}, int'(if0.de), PIPE ? 0 : 1);
    chk({tag, "_small_x"}, int'(if1.x), 0);
    chk({tag, "_small_y"}, int'(if1.y), 0);
    chk({tag, "_small_fs"}, int'(if1.frame_start), 1);
  endtask

  initial begin
    int hs_low, de_hi, le_cnt, hs_fall_x, fs_cnt, vs_low, de_small, xs, found;

    chk_en = 1'b1;
    repeat (3) @(negedge clk_in);
    #1 chk_reset_state("reset");

    rst_n = 1'b1;
    @(posedge clk_in);
    #1 chk_first_edge("first_edge");

    // Line 0 of the default raster, sampled once per pixel.
    hs_low = 0; de_hi = 0; le_cnt = 0; hs_fall_x = -1;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk_in);
      if (!if0.hsync) begin
        hs_low++;
        if (hs_fall_x < 0) hs_fall_x = int'(if0.x);
      end
      if (if0.de) de_hi++;
      if (if0.line_end) le_cnt++;
    end
    chk("line_hsync_low_cycles", hs_low, 96);
    chk("line_de_high_cycles", de_hi, 640);
    chk("line_end_pulses", le_cnt, 1);
    chk("hsync_fall_x", hs_fall_x, PIPE ? 657 : 656);
    @(posedge clk_in);
    #1 chk("line_wrap_x", int'(if0.x), 0);
    chk("line_wrap_y", int'(if0.y), 1);

    // Two full frames of the small raster: 2 x (2 sync lines x 19) and 2 x (10 x 6).
    fs_cnt = 0; vs_low = 0; de_small = 0;
    for (int k = 0; k < 456; k++) begin
      @(negedge clk_in);
      if (if1.frame_start) fs_cnt++;
      if (!if1.vsync) vs_low++;
      if (if1.de) de_small++;
    end
    chk("small_frame_starts", fs_cnt, 2);
    chk("small_vsync_low_cycles", vs_low, 76);
    chk("small_de_high_cycles", de_small, 120);

    // ce high one clock in four: 80 clocks advance the raster 20 pixels.
    xs = int'(if0.x);
    for (int k = 0; k < 80; k++) begin
      ce = (k % 4 == 0);
      @(negedge clk_in);
    end
    chk("ce_quarter_advance", (int'(if0.x) - xs + 800) % 800, 20);
    ce = 1'b1;

    // Reset in the middle of a line, between clock edges.
    found = 0;
    for (int k = 0; k < 1000 && found == 0; k++) begin
      @(negedge clk_in);
      if (if0.x == 11'd300) found = 1;
    end
    chk("reach_x300", found, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("async_reset");
    repeat (2) @(negedge clk_in);
    #1 rst_n = 1'b1;
    @(posedge clk_in);
    #1 chk_first_edge("restart");

    repeat (300) @(negedge clk_in);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
